clock_time_reporter: RTL

//   Reads the current time from the clock datapath (hour/min/sec/msec) and sends it to the UART transmitter as ASCII.
//   On a request pulse it snapshots the time and streams the frame "HH:MM:SS.CC\r\n", one byte per UART TX handshake.

---
 rtl/clock_time_reporter_if.sv | 25 ++
 rtl/clock_time_reporter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/clock_time_reporter_if.sv
// Time-readout bus between clock_time_reporter and its neighbours:
// request and time fields in, UART TX handshake and status out.
interface clock_time_reporter_if;
  logic       i_req;
  logic [4:0] i_hour;
  logic [5:0] i_min;
  logic [5:0] i_sec;
  logic [6:0] i_msec;
  logic       i_tx_busy;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_busy;
  logic       o_done;
  logic       o_overrun;

  modport slave (
    input  i_req, i_hour, i_min, i_sec, i_msec, i_tx_busy,
    output o_tx_data, o_tx_start, o_busy, o_done, o_overrun
  );

  modport master (
    output i_req, i_hour, i_min, i_sec, i_msec, i_tx_busy,
    input  o_tx_data, o_tx_start, o_busy, o_done, o_overrun
  );
endinterface

// File: rtl/clock_time_reporter.sv
// Snapshots hour/min/sec/centisec on a request and streams them to uart_tx
// as ASCII "HH:MM:SS.CC\r\n", one byte per TX handshake.
module clock_time_reporter #(
  parameter int SEND_MSEC = 1,
  parameter int SEND_CRLF = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  clock_time_reporter_if.slave  bus
);

  localparam int NBYTES   = 8 + ((SEND_MSEC != 0) ? 3 : 0) + ((SEND_CRLF != 0) ? 2 : 0);
  localparam int CRLF_POS = (SEND_MSEC != 0) ? 11 : 8;
  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, ACK, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [4:0]  hour_q, hour_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  sec_q, sec_d;
  logic [6:0]  msec_q, msec_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  frame [16];

  function automatic logic [7:0] asc_tens(input logic [6:0] v);
    return 8'h30 + {4'd0, 4'(v / 7'd10)};
  endfunction

  function automatic logic [7:0] asc_ones(input logic [6:0] v);
    return 8'h30 + {4'd0, 4'(v % 7'd10)};
  endfunction

  // Frame bytes built from the snapshot; optional fields placed by parameter.
  always_comb begin
    for (int i = 0; i < 16; i++) frame[i] = 8'h00;
    frame[0] = asc_tens({2'b00, hour_q});
    frame[1] = asc_ones({2'b00, hour_q});
    frame[2] = 8'h3A;
    frame[3] = asc_tens({1'b0, min_q});
    frame[4] = asc_ones({1'b0, min_q});
    frame[5] = 8'h3A;
    frame[6] = asc_tens({1'b0, sec_q});
    frame[7] = asc_ones({1'b0, sec_q});
    if (SEND_MSEC != 0) begin
      frame[8]  = 8'h2E;
      frame[9]  = asc_tens(msec_q);
      frame[10] = asc_ones(msec_q);
    end
    if (SEND_CRLF != 0) begin
      frame[CRLF_POS]     = 8'h0D;
      frame[CRLF_POS + 1] = 8'h0A;
    end
  end

  // Next state, snapshot capture and registered output values.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    msec_d    = msec_q;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: if (bus.i_req) begin
        // all four fields from one edge keeps the frame coherent across rollover
        hour_d  = bus.i_hour;
        min_d   = bus.i_min;
        sec_d   = bus.i_sec;
        msec_d  = (bus.i_msec > 7'd99) ? 7'd99 : bus.i_msec;
        idx_d   = 4'd0;
        state_d = LOAD;
      end
      LOAD: begin
        tx_data_d = frame[idx_q];
        state_d   = START;
      end
      START: state_d = ACK;
      // uart_tx raises busy only the cycle after the start pulse
      ACK:   state_d = WAIT;
      WAIT: if (!bus.i_tx_busy) begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tx_start_d = (state_q == START);
    busy_d     = (state_d == LOAD) || (state_d == START) || (state_d == ACK) || (state_d == WAIT);
    done_d     = (state_d == DONE);
  end

  // State, snapshot and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      msec_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      msec_q     <= msec_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  // any request outside IDLE (DONE included) is dropped and flagged this cycle
  assign bus.o_overrun  = bus.i_req && (state_q != IDLE);

endmodule
